exe_muldiv_unit: RTL and testbench



---
 rtl/exe_muldiv_if.sv | 32 +++
 rtl/exe_muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_exe_muldiv_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/exe_muldiv_if.sv
// Handshake/result bundle between the ID/EX register and the EX-stage
// multiply/divide unit.
//   start      request strobe, sampled only when the unit is idle
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_in/b_in  rs / rt operands
//   alu_stall  high while an operation is in flight
//   done       one-cycle pulse, hi/lo/div_zero valid from this cycle
//   hi/lo      product halves, or remainder/quotient
//   div_zero   last divide had a zero divisor
interface exe_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a_in;
  logic [XLEN-1:0] b_in;
  logic            alu_stall;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            div_zero;

  modport master (
    output start, op, a_in, b_in,
    input  alu_stall, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a_in, b_in,
    output alu_stall, done, hi, lo, div_zero
  );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit for the EX stage.
// One bit per clock, fixed latency: a start accepted on edge E0 produces
// done (and new hi/lo) after edge E33. alu_stall holds upstream stages
// while the operation is in flight.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   exe_muldiv_if.slave (start/op/a_in/b_in in, stall/done/hi/lo/div_zero out)
module exe_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         rst,
  exe_muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              done_r, div_zero_r;
  logic [XLEN-1:0]   hi_r, lo_r;

  logic [1:0]        op_r;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   dsor;
  logic [XLEN-1:0]   acc_hi, acc_lo;
  logic              neg_q, neg_r, dz;

  logic              is_div, is_signed;
  logic              in_div, in_signed, in_bzero;
  logic [XLEN:0]     msum, rem_sh, trial;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v,
                                          input logic sgn);
    return (sgn && v < 0) ? XLEN'(-v) : XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v,
                                            input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2w(input logic [2*XLEN-1:0] v,
                                               input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign is_div    = op_r[1];
  assign is_signed = ~op_r[0];
  assign in_div    = bus.op[1];
  assign in_signed = ~bus.op[0];
  assign in_bzero  = (bus.b_in == '0);

  // One iteration of each algorithm. For multiply the multiplier lives in
  // dsor and is consumed LSB first; for divide acc_hi/acc_lo are rem/quo.
  always_comb begin
    msum   = {1'b0, acc_hi} + (dsor[0] ? {1'b0, mcand} : '0);
    rem_sh = {acc_hi, acc_lo[XLEN-1]};
    trial  = rem_sh - {1'b0, dsor};
  end

  // Sign fixup. A zero divisor leaves the raw dividend in rem and all ones
  // in quo, so negation is suppressed for that case.
  always_comb begin
    prod = neg_2w({acc_hi, acc_lo}, is_signed & neg_q);
    quo  = neg_w(acc_lo, is_signed & neg_q & ~dz);
    rem  = neg_w(acc_hi, is_signed & neg_r & ~dz);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (cnt == CNT_W'(XLEN-1)) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
    end else begin
      state  <= state_nxt;
      done_r <= 1'b0;
      case (state)
        IDLE:  if (bus.start) cnt <= '0;
        CALC:  cnt <= cnt + 1'b1;
        FIXUP: begin
          done_r     <= 1'b1;
          hi_r       <= is_div ? rem : prod[2*XLEN-1:XLEN];
          lo_r       <= is_div ? quo : prod[XLEN-1:0];
          div_zero_r <= is_div & dz;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers: operands are captured once at E0 and never re-read.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (bus.start) begin
        op_r   <= bus.op;
        mcand  <= mag(bus.a_in, in_signed);
        dsor   <= mag(bus.b_in, in_signed);
        neg_q  <= bus.a_in[XLEN-1] ^ bus.b_in[XLEN-1];
        neg_r  <= bus.a_in[XLEN-1];
        dz     <= in_div & in_bzero;
        acc_hi <= '0;
        // A zero divisor shifts the raw dividend through into rem.
        acc_lo <= !in_div ? '0 :
                  in_bzero ? bus.a_in : mag(bus.a_in, in_signed);
      end
      CALC: begin
        if (is_div) begin
          acc_hi <= trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
          acc_lo <= {acc_lo[XLEN-2:0], ~trial[XLEN]};
        end else begin
          acc_hi <= msum[XLEN:1];
          acc_lo <= {msum[0], acc_lo[XLEN-1:1]};
          dsor   <= dsor >> 1;
        end
      end
      default: ;
    endcase
  end

  assign bus.alu_stall = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;
  assign bus.div_zero  = div_zero_r;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
module tb_exe_muldiv_unit;

  localparam int XLEN = 32;

  logic clk;
  logic rst;

  exe_muldiv_if #(.XLEN(XLEN)) bus ();

  exe_muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t   e;
    longint sa, sb_, sp, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    e.dz = 1'b0;
    case (op)
      2'b00: begin
        sp   = sa * sb_;
        e.hi = sp[63:32];
        e.lo = sp[31:0];
      end
      2'b01: begin
        up   = {32'd0, a} * {32'd0, b};
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          e.hi = a;
          e.lo = 32'hFFFF_FFFF;
          e.dz = 1'b1;
        end else if (op == 2'b10) begin
          sq   = sa / sb_;
          sr   = sa % sb_;
          e.hi = sr[31:0];
          e.lo = sq[31:0];
        end else begin
          e.hi = a % b;
          e.lo = a / b;
        end
      end
    endcase
    return e;
  endfunction

  // Called just after a falling edge; start is sampled on the next rising edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    sb.push_back(model(op, a, b));
    bus.op    = op;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int repulse_at);
    int   cnt;
    bit   got;
    exp_t e;
    got = 0;
    cnt = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      cnt = i;
      if (i == 1) begin
        bus.start = 1'b0;
        // Operands may change freely once the operation is latched.
        bus.a_in  = $urandom;
        bus.b_in  = $urandom;
        chk({tag, "_stall_on"}, 64'(bus.alu_stall), 64'd1);
        chk({tag, "_done_low"}, 64'(bus.done), 64'd0);
      end
      if (i == repulse_at)     bus.start = 1'b1;
      if (i == repulse_at + 1) bus.start = 1'b0;
      if (bus.done) got = 1;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_latency"}, 64'(cnt), 64'd34);
      chk({tag, "_stall_off"}, 64'(bus.alu_stall), 64'd0);
      chk({tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
      chk({tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
      chk({tag, "_dz"}, 64'(bus.div_zero), 64'(e.dz));
    end
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bit          extra;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a_in  = '0;
    bus.b_in  = '0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(bus.alu_stall), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_dz", 64'(bus.div_zero), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_stall", 64'(bus.alu_stall), 64'd0);

    // Full-scale unsigned multiply
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 0);

    // Signed multiply, then a divide accepted in the done cycle
    issue(2'b00, 32'hFFFF_FFF9, 32'd6);
    wait_done("mult_neg", 0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 0);

    // Divide by zero, then a multiply clears div_zero
    issue(2'b11, 32'd100, 32'd0);
    wait_done("divu_zero", 0);
    issue(2'b01, 32'd3, 32'd4);
    wait_done("multu_small", 0);

    // Signed overflow case with a start re-pulsed mid-operation
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 10);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.alu_stall) extra = 1;
    end
    chk("repulse_ignored", 64'(extra), 64'd0);

    // Asynchronous reset in the middle of a divide
    issue(2'b11, 32'd1000, 32'd7);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_stall", 64'(bus.alu_stall), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_hi", 64'(bus.hi), 64'd0);
    chk("arst_lo", 64'(bus.lo), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(2'b11, 32'd17, 32'd5);
    wait_done("divu_after_rst", 0);

    // Random operations of all four opcodes
    for (int n = 0; n < 1000; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 15))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(rop, ra, rb);
      wait_done("rand", 0);
    end

    @(negedge clk);
    chk("final_done_low", 64'(bus.done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
